ps2_keycode_rx: RTL and testbench

// - PS/2 keyboard receiver. Deserialises device-to-host PS/2 frames and decodes Set-2 make/break codes.
// - Maintains a 4-slot held-key table, emitted as the same 32-bit keycode word the NIOS PIO delivers.
// - keycode_read consumes the word unchanged, so 2-player mode works with the NIOS/USB path absent.
// - Sits between the board PS/2 pins and the keycode mux in front of keycode_read.

---
 rtl/ps2_pkg.sv | 58 +++++
 rtl/ps2_set2_to_hid.sv | 36 +++
 rtl/ps2_keycode_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, byte constants and HID usage codes for the PS/2 keyboard receiver.
`timescale 1ns/1ps
package ps2_pkg;

  localparam int unsigned NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_E0,
    DEC_F0,
    DEC_E0F0
  } dec_state_t;

  localparam logic [7:0] PS2_E0     = 8'hE0;
  localparam logic [7:0] PS2_F0     = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR_00 = 8'h00;
  localparam logic [7:0] PS2_ERR_FF = 8'hFF;
  localparam logic [7:0] PS2_E1     = 8'hE1;

  localparam logic [7:0] HID_NONE     = 8'h00;
  localparam logic [7:0] HID_A        = 8'h04;
  localparam logic [7:0] HID_D        = 8'h07;
  localparam logic [7:0] HID_R        = 8'h15;
  localparam logic [7:0] HID_S        = 8'h16;
  localparam logic [7:0] HID_W        = 8'h1A;
  localparam logic [7:0] HID_ENTER    = 8'h28;
  localparam logic [7:0] HID_ESC      = 8'h29;
  localparam logic [7:0] HID_SPACE    = 8'h2C;
  localparam logic [7:0] HID_RIGHT    = 8'h4F;
  localparam logic [7:0] HID_LEFT     = 8'h50;
  localparam logic [7:0] HID_DOWN     = 8'h51;
  localparam logic [7:0] HID_UP       = 8'h52;
  localparam logic [7:0] HID_KP_ENTER = 8'h58;
  localparam logic [7:0] HID_KP2      = 8'h5A;
  localparam logic [7:0] HID_KP4      = 8'h5C;
  localparam logic [7:0] HID_KP6      = 8'h5E;
  localparam logic [7:0] HID_KP8      = 8'h60;
  localparam logic [7:0] HID_KP0      = 8'h62;

  // Controller replies and overrun markers carry no key information.
  function automatic logic is_ignored_byte(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK)    || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR_00) || (b == PS2_ERR_FF) ||
           (b == PS2_E1);
  endfunction

endpackage

// File: rtl/ps2_set2_to_hid.sv
// Combinational Set-2 scan code to USB HID usage lookup; key_i = {extended, code}.
`timescale 1ns/1ps
module ps2_set2_to_hid
  import ps2_pkg::*;
(
  input  logic [8:0] key_i,
  output logic [7:0] hid_o
);

  always_comb begin
    hid_o = HID_NONE;
    case (key_i)
      9'h01D: hid_o = HID_W;
      9'h01C: hid_o = HID_A;
      9'h01B: hid_o = HID_S;
      9'h023: hid_o = HID_D;
      9'h029: hid_o = HID_SPACE;
      9'h05A: hid_o = HID_ENTER;
      9'h076: hid_o = HID_ESC;
      9'h02D: hid_o = HID_R;
      9'h075: hid_o = HID_KP8;
      9'h072: hid_o = HID_KP2;
      9'h06B: hid_o = HID_KP4;
      9'h074: hid_o = HID_KP6;
      9'h070: hid_o = HID_KP0;
      // Extended codes reuse the keypad scan codes with an E0 prefix.
      9'h175: hid_o = HID_UP;
      9'h172: hid_o = HID_DOWN;
      9'h16B: hid_o = HID_LEFT;
      9'h174: hid_o = HID_RIGHT;
      9'h15A: hid_o = HID_KP_ENTER;
      default: hid_o = HID_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, decodes Set-2 make/break
// sequences and keeps a contiguous 4-slot held-key table packed into a 32-bit word.
`timescale 1ns/1ps
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [31:0] keycode,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_err,
  output logic        rollover
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  // ---------------- input synchronisers ----------------
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;
  logic       ps2_fall;
  logic       ps2_dat;

  // Idle bus level is high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign ps2_fall = clk_prev_q & ~clk_sync_q[1];
  assign ps2_dat  = dat_sync_q[1];

  // ---------------- RX frame FSM ----------------
  rx_state_t        rx_state_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shift_q;
  logic             parity_ok_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [7:0]       byte_data_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_state_q   <= RX_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      parity_ok_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (ps2_fall) begin
        tmo_cnt_q <= '0;
        case (rx_state_q)
          RX_IDLE: begin
            if (!ps2_dat) begin
              rx_state_q <= RX_DATA;
              bitcnt_q   <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_q  <= {ps2_dat, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) rx_state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_ok_q <= ^{ps2_dat, shift_q};
            rx_state_q  <= RX_STOP;
          end
          RX_STOP: begin
            if (ps2_dat && parity_ok_q) begin
              byte_data_q  <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end else if (rx_state_q != RX_IDLE) begin
        // A stalled device mid-frame must not wedge the receiver.
        if (tmo_cnt_q == TMO_LAST) begin
          rx_state_q  <= RX_IDLE;
          frame_err_q <= 1'b1;
          tmo_cnt_q   <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  // ---------------- translation ----------------
  dec_state_t dec_state_q;
  logic [8:0] xlate_key;
  logic [7:0] hid;
  logic       is_break;

  assign xlate_key = {(dec_state_q == DEC_E0) || (dec_state_q == DEC_E0F0), byte_data_q};
  assign is_break  = (dec_state_q == DEC_F0) || (dec_state_q == DEC_E0F0);

  ps2_set2_to_hid u_xlate (
    .key_i (xlate_key),
    .hid_o (hid)
  );

  // ---------------- slot table helpers ----------------
  logic [7:0]           slots_q        [NUM_SLOTS];
  logic [7:0]           slot_above     [NUM_SLOTS];
  logic [7:0]           make_slots_d   [NUM_SLOTS];
  logic [7:0]           break_slots_d  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [NUM_SLOTS-1:0] slot_empty;
  logic                 hit_seen;
  logic                 empty_seen;
  logic                 any_hit;
  logic                 any_empty;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign slot_hit[gi]       = (slots_q[gi] == hid);
    assign slot_empty[gi]     = (slots_q[gi] == HID_NONE);
    assign keycode[8*gi +: 8] = slots_q[gi];
    if (gi == NUM_SLOTS - 1) begin : g_top
      assign slot_above[gi] = HID_NONE;
    end else begin : g_mid
      assign slot_above[gi] = slots_q[gi+1];
    end
  end

  // Make fills the lowest empty slot; break pulls every slot above the match down one.
  always_comb begin
    hit_seen   = 1'b0;
    empty_seen = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      make_slots_d[i] = (slot_empty[i] && !empty_seen) ? hid : slots_q[i];
      empty_seen      = empty_seen | slot_empty[i];
      hit_seen        = hit_seen | slot_hit[i];
      break_slots_d[i] = hit_seen ? slot_above[i] : slots_q[i];
    end
    any_hit   = hit_seen;
    any_empty = empty_seen;
  end

  // ---------------- decoder FSM and table ----------------
  logic rollover_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dec_state_q <= DEC_IDLE;
      rollover_q  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= HID_NONE;
    end else if (frame_err_q) begin
      dec_state_q <= DEC_IDLE;
    end else if (byte_valid_q && !is_ignored_byte(byte_data_q)) begin
      if (byte_data_q == PS2_E0) begin
        if (dec_state_q == DEC_IDLE) dec_state_q <= DEC_E0;
      end else if (byte_data_q == PS2_F0) begin
        case (dec_state_q)
          DEC_IDLE: dec_state_q <= DEC_F0;
          DEC_E0:   dec_state_q <= DEC_E0F0;
          default:  dec_state_q <= dec_state_q;
        endcase
      end else begin
        dec_state_q <= DEC_IDLE;
        if (hid != HID_NONE) begin
          if (is_break) begin
            if (any_hit) slots_q <= break_slots_d;
          end else if (!any_hit) begin
            if (any_empty) slots_q <= make_slots_d;
            else           rollover_q <= 1'b1;
          end
        end
      end
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign rollover   = rollover_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed frame table, timeout and async-reset corners,
// then random key traffic checked against a queue-based model of the held-key table.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;

  localparam int HALF = 8;  // Clk cycles per PS/2 clock half-period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [31:0] keycode;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_err;
  logic        rollover;

  int n_checks = 0;
  int n_fail   = 0;
  int bv_cnt   = 0;
  int fe_cnt   = 0;

  always #5 clk = ~clk;

  ps2_keycode_rx dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .PS2_CLK    (ps2_clk),
    .PS2_DAT    (ps2_dat),
    .keycode    (keycode),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rollover   (rollover)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) bv_cnt++;
      if (frame_err)  fe_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Frame = start(0), 8 data LSB first, odd parity, stop(1).
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(b, bad_par, bad_stop, 11);
    ps2_dat = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] hid_map [int];
  logic [7:0] held[$];
  bit         m_ext, m_brk, m_roll;
  logic [7:0] m_last;

  function automatic bit is_ign(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};
  endfunction

  function automatic logic [31:0] model_kc();
    logic [31:0] kc = '0;
    foreach (held[i]) kc[8*i +: 8] = held[i];
    return kc;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] h;
    int idx[$];
    int key;
    if (is_ign(b)) return;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      key = m_ext ? 256 + int'(b) : int'(b);
      h = hid_map.exists(key) ? hid_map[key] : 8'h00;
      if (h != 8'h00) begin
        idx = held.find_first_index(x) with (x == h);
        if (m_brk) begin
          if (idx.size() > 0) held.delete(idx[0]);
        end else if (idx.size() == 0) begin
          if (held.size() < 4) held.push_back(h);
          else m_roll = 1'b1;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int bv0, fe0;
    bit bad;
    bad = bad_par | bad_stop;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_frame(b, bad_par, bad_stop);
    if (bad) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_last = b;
      model_byte(b);
    end
    $display("frame %h par_err=%0d stop_err=%0d -> keycode=%h byte=%h roll=%0d",
             b, bad_par, bad_stop, keycode, byte_data, rollover);
    check("rnd_keycode",  keycode, model_kc());
    check("rnd_rollover", 32'(rollover), 32'(m_roll));
    check("rnd_byte",     32'(byte_data), 32'(m_last));
    check("rnd_bv_count", 32'(bv_cnt - bv0), bad ? 32'd0 : 32'd1);
    check("rnd_fe_count", 32'(fe_cnt - fe0), bad ? 32'd1 : 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          bad_stop;
    logic [31:0] kc;
    bit          roll;
    logic [7:0]  bd;
    int          nbv;
    int          nfe;
  } vec_t;

  vec_t vec[$];

  logic [7:0] plain_codes [13] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76,
                                   8'h2D, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h70};
  logic [7:0] ext_codes   [5]  = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
  logic [7:0] ign_codes   [7]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};

  initial begin
    int bv0, fe0, cycles;
    logic [7:0] seq[$];
    logic [7:0] code;
    bit ext;
    int r;

    hid_map[8'h1D] = 8'h1A; hid_map[8'h1C] = 8'h04; hid_map[8'h1B] = 8'h16;
    hid_map[8'h23] = 8'h07; hid_map[8'h29] = 8'h2C; hid_map[8'h5A] = 8'h28;
    hid_map[8'h76] = 8'h29; hid_map[8'h2D] = 8'h15; hid_map[8'h75] = 8'h60;
    hid_map[8'h72] = 8'h5A; hid_map[8'h6B] = 8'h5C; hid_map[8'h74] = 8'h5E;
    hid_map[8'h70] = 8'h62;
    hid_map[256+8'h75] = 8'h52; hid_map[256+8'h72] = 8'h51; hid_map[256+8'h6B] = 8'h50;
    hid_map[256+8'h74] = 8'h4F; hid_map[256+8'h5A] = 8'h58;

    //            byte  par stp keycode       roll byte  bv fe
    vec.push_back('{8'h1D, 0, 0, 32'h0000001A, 0, 8'h1D, 1, 0});
    vec.push_back('{8'hF0, 0, 0, 32'h0000001A, 0, 8'hF0, 1, 0});
    vec.push_back('{8'h1D, 0, 0, 32'h00000000, 0, 8'h1D, 1, 0});
    vec.push_back('{8'hE0, 0, 0, 32'h00000000, 0, 8'hE0, 1, 0});
    vec.push_back('{8'h75, 0, 0, 32'h00000052, 0, 8'h75, 1, 0});
    vec.push_back('{8'h1C, 0, 0, 32'h00000452, 0, 8'h1C, 1, 0});
    vec.push_back('{8'h23, 0, 0, 32'h00070452, 0, 8'h23, 1, 0});
    vec.push_back('{8'h29, 0, 0, 32'h2C070452, 0, 8'h29, 1, 0});
    vec.push_back('{8'h5A, 0, 0, 32'h2C070452, 1, 8'h5A, 1, 0});
    vec.push_back('{8'hE0, 0, 0, 32'h2C070452, 1, 8'hE0, 1, 0});
    vec.push_back('{8'hF0, 0, 0, 32'h2C070452, 1, 8'hF0, 1, 0});
    vec.push_back('{8'h75, 0, 0, 32'h002C0704, 1, 8'h75, 1, 0});
    vec.push_back('{8'h1C, 1, 0, 32'h002C0704, 1, 8'h75, 0, 1});
    vec.push_back('{8'hF0, 0, 0, 32'h002C0704, 1, 8'hF0, 1, 0});
    vec.push_back('{8'h1C, 0, 0, 32'h00002C07, 1, 8'h1C, 1, 0});
    vec.push_back('{8'h29, 0, 1, 32'h00002C07, 1, 8'h1C, 0, 1});
    vec.push_back('{8'hF0, 0, 0, 32'h00002C07, 1, 8'hF0, 1, 0});
    vec.push_back('{8'hAA, 0, 0, 32'h00002C07, 1, 8'hAA, 1, 0});
    vec.push_back('{8'h29, 0, 0, 32'h00000007, 1, 8'h29, 1, 0});
    vec.push_back('{8'hF0, 0, 0, 32'h00000007, 1, 8'hF0, 1, 0});
    vec.push_back('{8'h5A, 0, 1, 32'h00000007, 1, 8'hF0, 0, 1});
    vec.push_back('{8'h1C, 0, 0, 32'h00000407, 1, 8'h1C, 1, 0});

    // Reset values, held and after release.
    repeat (4) @(negedge clk);
    check("reset_keycode",    keycode, 32'h0);
    check("reset_byte_data",  32'(byte_data), 32'h0);
    check("reset_byte_valid", 32'(byte_valid), 32'h0);
    check("reset_frame_err",  32'(frame_err), 32'h0);
    check("reset_rollover",   32'(rollover), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_keycode", keycode, 32'h0);

    foreach (vec[i]) begin
      bv0 = bv_cnt;
      fe0 = fe_cnt;
      send_frame(vec[i].b, vec[i].bad_par, vec[i].bad_stop);
      $display("vec %0d frame %h -> keycode=%h byte=%h roll=%0d", i, vec[i].b, keycode, byte_data, rollover);
      check($sformatf("vec%0d_keycode", i),  keycode, vec[i].kc);
      check($sformatf("vec%0d_rollover", i), 32'(rollover), 32'(vec[i].roll));
      check($sformatf("vec%0d_byte", i),     32'(byte_data), 32'(vec[i].bd));
      check($sformatf("vec%0d_bv_count", i), 32'(bv_cnt - bv0), 32'(vec[i].nbv));
      check($sformatf("vec%0d_fe_count", i), 32'(fe_cnt - fe0), 32'(vec[i].nfe));
    end

    // Timeout: start + 4 data bits, then the clock stays high.
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_bits(8'h23, 1'b0, 1'b0, 5);
    ps2_dat = 1'b1;
    cycles = 0;
    while (cycles < 5400 && fe_cnt == fe0) begin
      @(negedge clk);
      cycles++;
    end
    $display("timeout frame: frame_err after %0d cycles", cycles);
    check("timeout_err_count", 32'(fe_cnt - fe0), 32'd1);
    check("timeout_not_early", 32'(cycles >= 4900), 32'd1);
    check("timeout_no_byte",   32'(bv_cnt - bv0), 32'd0);
    repeat (4) @(negedge clk);
    bv0 = bv_cnt;
    send_frame(8'h23, 1'b0, 1'b0);
    $display("frame 23 after timeout -> keycode=%h byte=%h", keycode, byte_data);
    check("after_timeout_byte",    32'(byte_data), 32'h23);
    check("after_timeout_bv",      32'(bv_cnt - bv0), 32'd1);
    check("after_timeout_keycode", keycode, 32'h00000407);

    // Asynchronous reset partway through a frame (during data bit 5).
    send_bits(8'h1C, 1'b0, 1'b0, 6);
    #3 rst_n = 1'b0;
    #1;
    $display("async reset mid-frame -> keycode=%h byte=%h roll=%0d", keycode, byte_data, rollover);
    check("async_rst_keycode",  keycode, 32'h0);
    check("async_rst_byte",     32'(byte_data), 32'h0);
    check("async_rst_rollover", 32'(rollover), 32'h0);
    check("async_rst_bv",       32'(byte_valid), 32'h0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    held.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_roll = 1'b0; m_last = 8'h00;
    run_frame(8'h1D, 1'b0, 1'b0);
    check("after_reset_W_held", keycode, 32'h0000001A);

    // Random key traffic.
    for (int ev = 0; ev < 60; ev++) begin
      seq.delete();
      r = $urandom_range(0, 9);
      if (r < 6) begin
        ext  = 1'b0;
        code = plain_codes[$urandom_range(0, 12)];
      end else if (r < 9) begin
        ext  = 1'b1;
        code = ext_codes[$urandom_range(0, 4)];
      end else begin
        ext = 1'($urandom_range(0, 1));
        do code = 8'($urandom_range(0, 255));
        while (code == 8'hE0 || code == 8'hF0 || is_ign(code));
      end
      if (ext) seq.push_back(8'hE0);
      if ($urandom_range(0, 1) == 1) seq.push_back(8'hF0);
      seq.push_back(code);
      if ($urandom_range(0, 5) == 0)
        seq.insert($urandom_range(0, seq.size() - 1), ign_codes[$urandom_range(0, 6)]);
      foreach (seq[k]) begin
        if ($urandom_range(0, 11) == 0) begin
          r = $urandom_range(0, 1);
          run_frame(8'($urandom_range(0, 255)), r[0], ~r[0]);
        end
        run_frame(seq[k], 1'b0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
